// File: rtl/system16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : system16_pkg                                               |
// | Purpose : Shared constants and types for the system16 I/O port.      |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package system16_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] IO_SW   = 2'd0;
  localparam logic [1:0] IO_LED  = 2'd1;
  localparam logic [1:0] IO_EDGE = 2'd2;
  localparam logic [1:0] IO_CTRL = 2'd3;

  localparam int CTRL_IE = 0;

  typedef enum logic [0:0] {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

endpackage
`default_nettype wire

// File: rtl/system16_io_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : system16_io_port_if                                        |
// | Purpose : CPU data-bus connection for the switch/LED peripheral.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface system16_io_port_if;
  import system16_pkg::*;

  logic              cs;
  logic              we;
  logic [1:0]        addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (output cs, we, addr, wdata, input rdata);
  modport slave  (input cs, we, addr, wdata, output rdata);

endinterface
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : switch_debounce                                            |
// | Purpose : Two-flop synchroniser plus vector debouncer, one counter.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module switch_debounce
  import system16_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_cand,
  output logic             commit
);

  localparam int                 c_cnt_w    = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_sync2;
  logic [WIDTH-1:0]   r_cand;
  logic [WIDTH-1:0]   r_sw_db;
  logic [c_cnt_w-1:0] r_cnt;
  db_state_t          r_state;

  db_state_t          w_state_nxt;
  logic [WIDTH-1:0]   w_cand_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic               w_commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= DB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Any movement on the synchronised input restarts the count, even from COUNT.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    if (r_sync2 != r_cand) begin
      w_cand_nxt  = r_sync2;
      w_cnt_nxt   = '0;
      w_state_nxt = DB_COUNT;
    end else if (r_state == DB_COUNT) begin
      if (r_cnt == c_cnt_last) begin
        w_commit    = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = DB_IDLE;
      end else begin
        w_cnt_nxt = r_cnt + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_cnt   <= '0;
      r_sw_db <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_commit) begin
        r_sw_db <= r_cand;
      end
    end
  end

  // commit marks the cycle whose closing edge loads sw_cand into sw_db.
  assign sw_db   = r_sw_db;
  assign sw_cand = r_cand;
  assign commit  = w_commit;

endmodule
`default_nettype wire

// File: rtl/system16_io_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : system16_io_port                                           |
// | Purpose : Memory-mapped switch/LED port with change-flag interrupt.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module system16_io_port
  import system16_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  system16_io_port_if.slave   bus,
  input  logic [DATA_W-1:0]   switches,
  output logic [DATA_W-1:0]   leds,
  output logic                irq
);

  logic [DATA_W-1:0] w_sw_db;
  logic [DATA_W-1:0] w_sw_cand;
  logic              w_commit;

  logic [DATA_W-1:0] r_leds;
  logic [DATA_W-1:0] r_edge;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ie;
  logic              r_primed;
  logic              r_irq;

  logic              w_wr;
  logic              w_rd;
  logic [DATA_W-1:0] w_edge_set;
  logic [DATA_W-1:0] w_w1c;
  logic [DATA_W-1:0] w_ctrl;
  logic [DATA_W-1:0] w_rd_mux;

  switch_debounce #(
    .WIDTH           (DATA_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .switches (switches),
    .sw_db    (w_sw_db),
    .sw_cand  (w_sw_cand),
    .commit   (w_commit)
  );

  always_comb begin
    w_wr       = bus.cs & bus.we;
    w_rd       = bus.cs & ~bus.we;
    // The first commit after reset only establishes a baseline.
    w_edge_set = (w_commit && r_primed) ? (w_sw_db ^ w_sw_cand) : '0;
    w_w1c      = (w_wr && (bus.addr == IO_EDGE)) ? bus.wdata : '0;
    w_ctrl          = '0;
    w_ctrl[CTRL_IE] = r_ie;
    w_rd_mux        = '0;
    case (bus.addr)
      IO_SW:   w_rd_mux = w_sw_db;
      IO_LED:  w_rd_mux = r_leds;
      IO_EDGE: w_rd_mux = r_edge;
      default: w_rd_mux = w_ctrl;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_leds   <= '0;
      r_edge   <= '0;
      r_rdata  <= '0;
      r_ie     <= 1'b0;
      r_primed <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (bus.addr == IO_LED)) begin
        r_leds <= bus.wdata;
      end
      if (w_wr && (bus.addr == IO_CTRL)) begin
        r_ie <= bus.wdata[CTRL_IE];
      end
      // A new change on the same edge as a clear keeps the bit set.
      r_edge <= (r_edge & ~w_w1c) | w_edge_set;
      if (w_commit) begin
        r_primed <= 1'b1;
      end
      r_irq <= r_ie & (|r_edge);
      if (w_rd) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign bus.rdata = r_rdata;
  assign leds      = r_leds;
  assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_system16_io_port.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_system16_io_port                                        |
// | Purpose : Scoreboard bench for the system16 switch/LED port.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_system16_io_port;
  import system16_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] switches;
  logic [15:0] leds;
  logic        irq;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  system16_io_port_if bus();

  system16_io_port #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.cs    = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 16'h0000;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    d = bus.rdata;
    bus_idle();
  endtask

  task automatic test_reset();
    logic [15:0] rd, e;
    reset = 1'b0;
    switches = 16'h1234;
    bus_idle();
    repeat (3) @(negedge clk);
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL reset_leds: got %h want 0000", leds); end
    checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h want 0000", bus.rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    exp_q.push_back(16'h1234);
    bus_read(IO_SW, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL reset_first_sw: got %h want %h", rd, e); end
    exp_q.push_back(16'h0000);
    bus_read(IO_EDGE, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL reset_first_edge: got %h want %h", rd, e); end
  endtask

  // Continuous SW reads while the switch changes pin down the exact commit edge.
  task automatic test_debounce();
    logic [15:0] rd, e;
    bus_write(IO_CTRL, 16'h0001);
    @(negedge clk);
    switches = 16'h1235;
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = IO_SW;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back((i >= 7) ? 16'h1235 : 16'h1234);
      exp_q.push_back((i >= 7) ? 16'h0001 : 16'h0000);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (bus.rdata !== e) begin errors++; $display("FAIL debounce_sw_cycle%0d: got %h want %h", i, bus.rdata, e); end
      e = exp_q.pop_front();
      checks++; if ({15'd0, irq} !== e) begin errors++; $display("FAIL debounce_irq_cycle%0d: got %b want %b", i, irq, e[0]); end
    end
    bus_idle();
    exp_q.push_back(16'h0001);
    bus_read(IO_EDGE, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL debounce_edge: got %h want %h", rd, e); end
  endtask

  task automatic test_w1c_race();
    logic [15:0] rd, e;
    @(negedge clk);
    switches = 16'h1234;
    repeat (6) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = IO_EDGE; bus.wdata = 16'h0001;
    @(negedge clk);
    bus_idle();
    exp_q.push_back(16'h0001);
    bus_read(IO_EDGE, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL w1c_race_edge: got %h want %h", rd, e); end
    bus_write(IO_EDGE, 16'h0001);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_hold: got %b want 1", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_fall: got %b want 0", irq); end
    exp_q.push_back(16'h0000);
    bus_read(IO_EDGE, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL w1c_clear_edge: got %h want %h", rd, e); end
  endtask

  task automatic test_glitch();
    logic [15:0] rd, e;
    @(negedge clk);
    switches = 16'h9234;
    repeat (3) @(negedge clk);
    switches = 16'h1234;
    repeat (12) @(negedge clk);
    exp_q.push_back(16'h1234);
    bus_read(IO_SW, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL glitch_sw: got %h want %h", rd, e); end
    exp_q.push_back(16'h0000);
    bus_read(IO_EDGE, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL glitch_edge: got %h want %h", rd, e); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b want 0", irq); end
  endtask

  task automatic test_led_regs();
    logic [15:0] rd, e;
    bus_write(IO_LED, 16'hA5A5);
    checks++; if (leds !== 16'hA5A5) begin errors++; $display("FAIL led_pins: got %h want a5a5", leds); end
    exp_q.push_back(16'hA5A5);
    bus_read(IO_LED, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL led_readback: got %h want %h", rd, e); end
    bus_write(IO_SW, 16'hFFFF);
    exp_q.push_back(16'h1234);
    bus_read(IO_SW, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL sw_readonly: got %h want %h", rd, e); end
    bus_write(IO_CTRL, 16'hFFFF);
    exp_q.push_back(16'h0001);
    bus_read(IO_CTRL, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL ctrl_mask: got %h want %h", rd, e); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] rd, e;
    @(negedge clk);
    switches = 16'h00F0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL midrst_leds: got %h want 0000", leds); end
    checks++; if (bus.rdata !== 16'h0000) begin errors++; $display("FAIL midrst_rdata: got %h want 0000", bus.rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b want 0", irq); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    exp_q.push_back(16'h00F0);
    bus_read(IO_SW, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL midrst_sw: got %h want %h", rd, e); end
    exp_q.push_back(16'h0000);
    bus_read(IO_EDGE, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL midrst_edge: got %h want %h", rd, e); end
    exp_q.push_back(16'h0000);
    bus_read(IO_CTRL, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL midrst_ctrl: got %h want %h", rd, e); end
    exp_q.push_back(16'h0000);
    bus_read(IO_LED, rd); e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL midrst_led: got %h want %h", rd, e); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_w1c_race();
    test_glitch();
    test_led_regs();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
